// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   breathe_state_t : duty sequencer state encoding
//   PWM_PERIOD      : default PWM period in clk cycles (counter span 0..100)
package pwm_pkg;

  localparam int PWM_PERIOD = 101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIXED   = 3'd1,
    RISE    = 3'd2,
    HOLD_HI = 3'd3,
    FALL    = 3'd4,
    HOLD_LO = 3'd5
  } breathe_state_t;

endpackage

// File: rtl/frame_timer.sv
// PWM frame timer: counts clk cycles within a PWM period and marks frame edges.
// Latency: boundary_o is combinational from pcnt; frame_start_o is high the cycle after a boundary edge.
// Backpressure: none; free-running while en_i is high, parked at PERIOD-1 while low.
//
// Ports:
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   en_i          : run enable
//   boundary_o    : high when the coming edge closes a frame (en_i=1 and pcnt=PERIOD-1)
//   frame_start_o : one-cycle pulse in the first cycle of each frame
module frame_timer #(
  parameter int PERIOD = 101
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic boundary_o,
  output logic frame_start_o
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              frame_start_q;

  // Parking the counter at its last value makes the first enabled edge a boundary.
  assign boundary_o = en_i && (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (!en_i) begin
      pcnt_d = PCNT_LAST;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q        <= PCNT_LAST;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      frame_start_q <= boundary_o;
    end
  end

  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/duty_breather.sv
// Duty-code sequencer for the PWM stage: triangular breathing sweep or fixed pass-through.
// Latency: duty/cycle_done update on the boundary edge, aligned with frame_start.
// Backpressure: none; outputs are free-running while en is high.
//
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   en          : run enable; low parks everything in IDLE with duty=0
//   mode        : 1 = breathe, 0 = fixed code from duty_fixed
//   duty_fixed  : fixed-mode code, sampled at frame boundaries only
//   duty        : registered duty code to the PWM stage
//   frame_start : one-cycle pulse in the first cycle of each frame
//   cycle_done  : one-cycle pulse (with frame_start) when a breathe cycle ends
module duty_breather
  import pwm_pkg::*;
#(
  parameter int DUTY_W           = 4,
  parameter int PERIOD           = PWM_PERIOD,
  parameter int PERIODS_PER_STEP = 4,
  parameter int HOLD_PERIODS     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [DUTY_W-1:0] duty_fixed,
  output logic [DUTY_W-1:0] duty,
  output logic              frame_start,
  output logic              cycle_done
);

  // fcnt only needs to reach the larger of the step and hold frame counts.
  localparam int FCNT_MAX = (PERIODS_PER_STEP > HOLD_PERIODS) ? PERIODS_PER_STEP : HOLD_PERIODS;
  localparam int FCNT_W   = (FCNT_MAX > 1) ? $clog2(FCNT_MAX) : 1;

  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [FCNT_W-1:0] STEP_LAST = FCNT_W'(PERIODS_PER_STEP - 1);
  localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_PERIODS - 1);

  breathe_state_t    state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              cycle_done_q, cycle_done_d;

  logic              boundary;
  logic              step_due;
  logic              hold_due;
  logic [DUTY_W-1:0] duty_up;
  logic [DUTY_W-1:0] duty_dn;
  logic [FCNT_W-1:0] fcnt_inc;

  frame_timer #(
    .PERIOD(PERIOD)
  ) u_frame_timer (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .boundary_o    (boundary),
    .frame_start_o (frame_start)
  );

  assign step_due = (fcnt_q == STEP_LAST);
  assign hold_due = (fcnt_q == HOLD_LAST);
  assign fcnt_inc = fcnt_q + FCNT_W'(1);

  // Saturating steps so the code can never wrap.
  assign duty_up = (duty_q == DUTY_MAX) ? duty_q : duty_q + DUTY_W'(1);
  assign duty_dn = (duty_q == '0)       ? duty_q : duty_q - DUTY_W'(1);

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    fcnt_d       = fcnt_q;
    cycle_done_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      duty_d  = '0;
      fcnt_d  = '0;
    end else if (boundary) begin
      // Fixed mode wins over any step or hold in progress.
      if (!mode) begin
        state_d = FIXED;
        duty_d  = duty_fixed;
        fcnt_d  = '0;
      end else begin
        case (state_q)
          IDLE, FIXED: begin
            state_d = RISE;
            duty_d  = '0;
            fcnt_d  = '0;
          end
          RISE: begin
            if (step_due) begin
              fcnt_d = '0;
              duty_d = duty_up;
              if (duty_up == DUTY_MAX) begin
                state_d = HOLD_HI;
              end
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
          HOLD_HI: begin
            if (hold_due) begin
              state_d = FALL;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
          FALL: begin
            if (step_due) begin
              fcnt_d = '0;
              duty_d = duty_dn;
              if (duty_dn == '0) begin
                state_d = HOLD_LO;
              end
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
          HOLD_LO: begin
            if (hold_due) begin
              state_d      = RISE;
              fcnt_d       = '0;
              cycle_done_d = 1'b1;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
          default: begin
            state_d = IDLE;
            duty_d  = '0;
            fcnt_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      fcnt_q       <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      fcnt_q       <= fcnt_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign duty       = duty_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: doc/duty_breather.md
# duty_breather

Duty-code sequencer that feeds the PWM stage's `duty` input. It produces a triangular "breathing" sweep (0 → max → 0 with dwell at both ends) or passes through a fixed code. Its internal frame counter matches the PWM period, and `duty` changes only on a period boundary, so the PWM stage never sees a mid-period change. It also emits a frame-start pulse for the PWM stage and for monitors.

## Interface
- `DUTY_W`, default 4: width of the duty code; max code is 2^DUTY_W−1.
- `PERIOD`, default 101: PWM period in clk cycles. Must match the downstream counter span 0..100. Legal range is ≥2.
- `PERIODS_PER_STEP`, default 4: frames per ±1 duty step. Must be ≥1.
- `HOLD_PERIODS`, default 8: dwell frames at the max and zero ends. Must be ≥1.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `en` in, 1: run enable.
- `mode` in, 1: 1 = breathe, 0 = fixed.
- `duty_fixed` in, DUTY_W: code used in fixed mode. Sampled at boundaries only.
- `duty` out, DUTY_W: registered duty code to the PWM stage.
- `frame_start` out, 1: one-cycle pulse in the first cycle of each frame.
- `cycle_done` out, 1: one-cycle pulse when a full breathe cycle ends.

## Operation
- Reset values: `duty`=0, `frame_start`=0, `cycle_done`=0, state IDLE. Internal counters: `pcnt`=PERIOD−1, `fcnt`=0.
- `pcnt` width is $clog2(PERIOD).
  - While `en`=0, `pcnt` is held at PERIOD−1.
  - While `en`=1, `pcnt` increments and wraps from PERIOD−1 to 0.
- Boundary: any edge with `en`=1 and `pcnt`=PERIOD−1. Every state, `duty`, `fcnt` and mode decision is made only at a boundary.
- `fcnt` counts frames within the current step or hold. It resets to 0 whenever the state or duty step changes.
- States and transitions, all evaluated at a boundary:
  - IDLE:
    - With `mode`=1, go to RISE and set `duty`=0.
    - With `mode`=0, go to FIXED and set `duty`=`duty_fixed`.
  - FIXED: set `duty`=`duty_fixed` at every boundary. If `mode`=1, go to RISE with `duty`=0.
  - RISE:
    - When `fcnt`=PERIODS_PER_STEP−1, increment `duty`.
    - If the new `duty` is the max code, go to HOLD_HI.
  - HOLD_HI: when `fcnt`=HOLD_PERIODS−1, go to FALL. `duty` is unchanged.
  - FALL:
    - When `fcnt`=PERIODS_PER_STEP−1, decrement `duty`.
    - If the new `duty` is 0, go to HOLD_LO.
  - HOLD_LO: when `fcnt`=HOLD_PERIODS−1, go to RISE and pulse `cycle_done`.
  - Any breathe state with `mode`=0 goes to FIXED with `duty`=`duty_fixed`. The mode check has priority over step and hold logic.
- `duty` never wraps.
  - RISE saturates at the max code.
  - FALL saturates at 0.
  - Arithmetic is unsigned, DUTY_W bits.
- Deasserting `en`:
  - At the next edge, return to IDLE, set `duty`=0, hold `pcnt`=PERIOD−1, clear `fcnt`.
  - No pulses are produced while `en`=0.
- `rst_n` low mid-frame immediately forces all reset values, whatever the state.

## Timing
- First boundary is the first edge with `en`=1. `frame_start` is high for the cycle that follows it.
- After that, `frame_start` is high once every PERIOD cycles.
- `duty` takes its new value in the same cycle that `frame_start` is high. Latency from a boundary edge to the new `duty` is 0 cycles, because `duty` is registered at that edge.
- `cycle_done` is high together with `frame_start` on the frame where HOLD_LO → RISE.
- Breathe cycle length: (2·(2^DUTY_W−1)·PERIODS_PER_STEP + 2·HOLD_PERIODS) frames.
  - The first cycle after IDLE is identical, because RISE starts with `duty`=0 and `fcnt`=0.
- `mode` and `duty_fixed` changes between boundaries are invisible until the next boundary.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `breathe_state_t` (IDLE, FIXED, RISE, HOLD_HI, FALL, HOLD_LO);
  - the default period constant `PWM_PERIOD = 101`.
- One natural sub-module, `frame_timer`. It contains `pcnt` and produces the boundary strobe and `frame_start`. The PWM stage can reuse it.
- The state machine and `duty` register live in the top module.

## Test plan
All scenarios use PERIOD=5, PERIODS_PER_STEP=2, HOLD_PERIODS=3, DUTY_W=2. Frame 0 is the first boundary.
- Reset then `en`=1, `mode`=1:
  - `duty` reads 0,1,2,3 at frames 0,2,4,6;
  - `duty` stays 3 through frame 8 (HOLD_HI, entered at frame 6);
  - FALL is entered at frame 9;
  - `duty` reads 2,1,0 at frames 11,13,15;
  - `cycle_done` pulses at frame 18;
  - `frame_start` pulses every 5 cycles.
- `mode`=0, `duty_fixed`=2, then change `duty_fixed` to 1 two cycles into a frame → `duty` stays 2 until the next `frame_start`, then reads 1.
- Breathing at `duty`=2 in RISE, switch `mode` to 0 mid-frame → at the next boundary the state is FIXED and `duty`=`duty_fixed`. No further steps occur.
- `en` dropped during HOLD_HI → next edge gives `duty`=0 and state IDLE, with no further `frame_start`. Re-enabling restarts the sequence from frame 0 exactly as in the first scenario.
- `rst_n` pulsed low mid-frame during FALL → all outputs are 0 asynchronously, before the next clk edge.
- Default parameters → `frame_start` spacing is exactly 101 cycles and `duty` never exceeds 15 over two full breathe cycles.
